// File: rtl/wide_add_pkg.sv
// rtl/wide_add_pkg.sv - shared types and default sizes for the wide add sequencer
package wide_add_pkg;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_NUM_BYTES   = 4;
   localparam int DEF_TOTAL_WIDTH = DEF_DATA_WIDTH * DEF_NUM_BYTES;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/wide_add_sequencer_if.sv
// rtl/wide_add_sequencer_if.sv - request/result bundle; sub present when WIDE_ADD_SUB_EN is defined
interface wide_add_sequencer_if
   import wide_add_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_BYTES  = DEF_NUM_BYTES
);
   logic                            start;
   logic [DATA_WIDTH*NUM_BYTES-1:0] op_a;
   logic [DATA_WIDTH*NUM_BYTES-1:0] op_b;
   logic                            carry_in;
`ifdef WIDE_ADD_SUB_EN
   logic                            sub;
`endif
   logic                            busy;
   logic                            done;
   logic [DATA_WIDTH*NUM_BYTES-1:0] sum;
   logic                            carry_out;
   logic                            overflow;

`ifdef WIDE_ADD_SUB_EN
   modport master (output start, op_a, op_b, carry_in, sub,
                   input  busy, done, sum, carry_out, overflow);
   modport slave  (input  start, op_a, op_b, carry_in, sub,
                   output busy, done, sum, carry_out, overflow);
`else
   modport master (output start, op_a, op_b, carry_in,
                   input  busy, done, sum, carry_out, overflow);
   modport slave  (input  start, op_a, op_b, carry_in,
                   output busy, done, sum, carry_out, overflow);
`endif

endinterface

// File: rtl/wide_add_sequencer_add_slice.sv
// rtl/wide_add_sequencer_add_slice.sv - combinational DATA_WIDTH ripple slice exposing the carry into its top bit
module add_slice #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  cin,
   output logic [DATA_WIDTH-1:0] s,
   output logic                  cout,
   output logic                  c_msb
);
   logic [DATA_WIDTH-1:0] w_low;

   // Low bits added one bit wider so their carry-out is the carry into the MSB
   assign w_low = {1'b0, a[DATA_WIDTH-2:0]} + {1'b0, b[DATA_WIDTH-2:0]}
                + {{(DATA_WIDTH-1){1'b0}}, cin};
   assign c_msb = w_low[DATA_WIDTH-1];
   assign s     = {a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1] ^ c_msb, w_low[DATA_WIDTH-2:0]};
   assign cout  = (a[DATA_WIDTH-1] & b[DATA_WIDTH-1])
                | (c_msb & (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]));

endmodule

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - byte-serial wide adder reusing one slice per cycle, LSB first
// Optional subtract support enabled by defining WIDE_ADD_SUB_EN.
module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_BYTES  = DEF_NUM_BYTES
) (
   input logic                  clk,
   input logic                  rst_n,
   wide_add_sequencer_if.slave  bus
);
   localparam int TOTAL_W = DATA_WIDTH * NUM_BYTES;
   localparam int IDX_W   = $clog2(NUM_BYTES);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [TOTAL_W-1:0]   r_a;
   logic [TOTAL_W-1:0]   r_b;
   logic [TOTAL_W-1:0]   r_sum;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_carry;
   logic                 r_carry_out;
   logic                 r_overflow;

   logic                 w_sub;
   logic                 w_last;
   logic [DATA_WIDTH-1:0] w_a_byte;
   logic [DATA_WIDTH-1:0] w_b_byte;
   logic [DATA_WIDTH-1:0] w_s;
   logic                 w_cout;
   logic                 w_c_msb;

`ifdef WIDE_ADD_SUB_EN
   assign w_sub = bus.sub;
`else
   assign w_sub = 1'b0;
`endif

   assign w_last   = (r_idx == IDX_W'(NUM_BYTES - 1));
   assign w_a_byte = r_a[r_idx*DATA_WIDTH +: DATA_WIDTH];
   assign w_b_byte = r_b[r_idx*DATA_WIDTH +: DATA_WIDTH];

   add_slice #(.DATA_WIDTH(DATA_WIDTH)) u_slice (
      .a     (w_a_byte),
      .b     (w_b_byte),
      .cin   (r_carry),
      .s     (w_s),
      .cout  (w_cout),
      .c_msb (w_c_msb)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  // Subtract is a + ~b + 1, so the inversion happens once at latch time
                  r_a     <= bus.op_a;
                  r_b     <= w_sub ? ~bus.op_b : bus.op_b;
                  r_carry <= w_sub ? 1'b1 : bus.carry_in;
                  r_idx   <= '0;
                  r_sum   <= '0;
               end
            end
            RUN: begin
               r_sum[r_idx*DATA_WIDTH +: DATA_WIDTH] <= w_s;
               r_carry <= w_cout;
               if (w_last) begin
                  r_carry_out <= w_cout;
                  r_overflow  <= w_c_msb ^ w_cout;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy      = (r_state == RUN);
   assign bus.done      = (r_state == DONE);
   assign bus.sum       = r_sum;
   assign bus.carry_out = r_carry_out;
   assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - directed self-checking bench for wide_add_sequencer (NUM_BYTES=4)
module tb_wide_add_sequencer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   wide_add_sequencer_if #(.DATA_WIDTH(8), .NUM_BYTES(4)) bus ();

   wide_add_sequencer #(.DATA_WIDTH(8), .NUM_BYTES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request and watches it to completion; latency is the posedge count
   // from acceptance to the edge that samples done (0 on timeout).
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, output logic [31:0] s, output logic co,
                        output logic ov, output int latency, output int busy_cnt,
                        output int done_cnt, output int both_cnt);
      bit seen;
      seen     = 0;
      latency  = 0;
      busy_cnt = 0;
      done_cnt = 0;
      both_cnt = 0;
      s  = 'x;
      co = 1'bx;
      ov = 1'bx;
      @(negedge clk);
      bus.op_a     = a;
      bus.op_b     = b;
      bus.carry_in = cin;
`ifdef WIDE_ADD_SUB_EN
      bus.sub      = sub;
`else
      if (sub) $display("note: sub request ignored in add-only build");
`endif
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.op_a     = 32'hDEAD_BEEF;
      bus.op_b     = 32'hCAFE_F00D;
      for (int n = 1; n <= 20; n++) begin
         if (bus.busy) busy_cnt++;
         if (bus.busy && bus.done) both_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (!seen) begin
               seen    = 1;
               latency = n;
               s  = bus.sum;
               co = bus.carry_out;
               ov = bus.overflow;
            end
         end else if (seen) begin
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op_a  = 32'h1111_1111;
      bus.op_b  = 32'h2222_2222;
      bus.carry_in = 1'b1;
`ifdef WIDE_ADD_SUB_EN
      bus.sub   = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl busy=%b done=%b required 0 0", bus.busy, bus.done);
      end
      n_checks++;
      if (bus.sum !== 32'h0 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_data sum=%h co=%b ov=%b required 0 0 0",
                  bus.sum, bus.carry_out, bus.overflow);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_wrap();
      logic [31:0] s; logic co, ov; int lat, bc, dc, bd;
      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, co, ov, lat, bc, dc, bd);
      n_checks++;
      if (s !== 32'h0000_0000) begin
         n_fail++; $display("FAIL wrap_sum got %h required 00000000", s);
      end
      n_checks++;
      if (co !== 1'b1 || ov !== 1'b0) begin
         n_fail++; $display("FAIL wrap_flags co=%b ov=%b required 1 0", co, ov);
      end
      n_checks++;
      if (lat !== 5) begin
         n_fail++; $display("FAIL wrap_latency got %0d edges required 5", lat);
      end
   endtask

   task automatic test_signed_overflow();
      logic [31:0] s; logic co, ov; int lat, bc, dc, bd;
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, co, ov, lat, bc, dc, bd);
      n_checks++;
      if (s !== 32'h8000_0000) begin
         n_fail++; $display("FAIL ovf_sum got %h required 80000000", s);
      end
      n_checks++;
      if (co !== 1'b0 || ov !== 1'b1) begin
         n_fail++; $display("FAIL ovf_flags co=%b ov=%b required 0 1", co, ov);
      end
   endtask

   task automatic test_carry_in();
      logic [31:0] s; logic co, ov; int lat, bc, dc, bd;
      do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, s, co, ov, lat, bc, dc, bd);
      n_checks++;
      if (s !== 32'h2345_678A || co !== 1'b0 || ov !== 1'b0) begin
         n_fail++; $display("FAIL cin_result sum=%h co=%b ov=%b required 2345678a 0 0", s, co, ov);
      end
      n_checks++;
      if (bc !== 4) begin
         n_fail++; $display("FAIL cin_busy_cycles got %0d required 4", bc);
      end
      n_checks++;
      if (dc !== 1 || bd !== 0) begin
         n_fail++; $display("FAIL cin_done_pulse width=%0d overlap=%0d required 1 0", dc, bd);
      end
      n_checks++;
      if (bus.sum !== 32'h2345_678A) begin
         n_fail++; $display("FAIL cin_sum_hold got %h required 2345678a", bus.sum);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] s1, s2;
      int first, second;
      first  = 0;
      second = 0;
      s1 = 'x;
      s2 = 'x;
      @(negedge clk);
      bus.op_a = 32'h0000_0001; bus.op_b = 32'h0000_0002; bus.carry_in = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.op_a = 32'h0000_0010; bus.op_b = 32'h0000_0020;
      for (int n = 1; n <= 30; n++) begin
         if (bus.done) begin
            if (first == 0) begin
               first = n; s1 = bus.sum;
            end else if (second == 0) begin
               second = n; s2 = bus.sum;
            end
         end
         if (second != 0) break;
         @(negedge clk);
      end
      bus.start = 1'b0;
      n_checks++;
      if (s1 !== 32'h0000_0003) begin
         n_fail++; $display("FAIL b2b_first_sum got %h required 00000003", s1);
      end
      n_checks++;
      if (s2 !== 32'h0000_0030) begin
         n_fail++; $display("FAIL b2b_second_sum got %h required 00000030", s2);
      end
      n_checks++;
      if (first == 0 || second - first !== 6) begin
         n_fail++; $display("FAIL b2b_gap got %0d cycles required 6", second - first);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_abort();
      logic [31:0] s; logic co, ov; int lat, bc, dc, bd;
      int spurious;
      spurious = 0;
      @(negedge clk);
      bus.op_a = 32'hAAAA_AAAA; bus.op_b = 32'h5555_5555; bus.carry_in = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 32'h0) begin
         n_fail++; $display("FAIL abort_outputs busy=%b done=%b sum=%h required 0 0 0",
                            bus.busy, bus.done, bus.sum);
      end
      rst_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (bus.done || bus.busy) spurious++;
      end
      n_checks++;
      if (spurious !== 0) begin
         n_fail++; $display("FAIL abort_no_done got %0d active cycles required 0", spurious);
      end
      do_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, s, co, ov, lat, bc, dc, bd);
      n_checks++;
      if (s !== 32'h0000_0002 || lat !== 5) begin
         n_fail++; $display("FAIL abort_recover sum=%h lat=%0d required 00000002 5", s, lat);
      end
   endtask

`ifdef WIDE_ADD_SUB_EN
   task automatic test_sub();
      logic [31:0] s; logic co, ov; int lat, bc, dc, bd;
      do_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, s, co, ov, lat, bc, dc, bd);
      n_checks++;
      if (s !== 32'hFFFF_FFFF || co !== 1'b0 || ov !== 1'b0) begin
         n_fail++; $display("FAIL sub_borrow sum=%h co=%b ov=%b required ffffffff 0 0", s, co, ov);
      end
      do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, s, co, ov, lat, bc, dc, bd);
      n_checks++;
      if (s !== 32'h7FFF_FFFF || co !== 1'b1 || ov !== 1'b1) begin
         n_fail++; $display("FAIL sub_overflow sum=%h co=%b ov=%b required 7fffffff 1 1", s, co, ov);
      end
      bus.sub = 1'b0;
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_wrap();
      test_signed_overflow();
      test_carry_in();
      test_back_to_back();
      test_reset_abort();
`ifdef WIDE_ADD_SUB_EN
      test_sub();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
